vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-timing generator for the 640x480@60 Hz display path. It runs on the 25 MHz pixel clock and produces the `DrawX`/`DrawY` coordinates and visible-area `blank` flag that the full-screen sprite renderers (character select, stage, HUD) consume. It also drives the active-low `hs`/`vs` sync pins, frame and line strobes, and a frame counter for animation. Sync outputs can be delayed to line up with the renderers' one-cycle ROM-plus-register latency.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `PIPE_DELAY`, 1: extra sync delay in cycles, legal range 1..4; only used when the sync-align macro is defined

Ports:
- `vga_clk` in 1: pixel clock, 25 MHz
- `reset` in 1: asynchronous, active-high
- `DrawX` out 10: current pixel column
- `DrawY` out 10: current pixel row
- `blank` out 1: 1 = visible pixel (renderers draw when high)
- `hs` out 1: horizontal sync, active-low
- `vs` out 1: vertical sync, active-low
- `line_start` out 1: one-cycle pulse when `DrawX` = 0
- `frame_start` out 1: one-cycle pulse when (`DrawX`,`DrawY`) = (0,0)
- `frame_count` out 16: number of completed frames, wraps

## Operation
- Internal counters `hc` run 0..H_TOTAL-1 and `vc` run 0..V_TOTAL-1, where H_TOTAL = 800 and V_TOTAL = 525 with the defaults.
- `hc` increments every cycle.
- At `hc` = H_TOTAL-1, `hc` returns to 0 and `vc` increments; `vc` wraps to 0 at V_TOTAL-1.
- All outputs are registered from the counter state, so every output lags `hc`/`vc` by one cycle.
- `DrawX` = `hc` and `DrawY` = `vc` over the full range, blanking regions included.
- `blank` = (`hc` < H_VISIBLE) && (`vc` < V_VISIBLE).
- `hs` is low for `hc` in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), which is [656,752) with defaults.
- `vs` is low for `vc` in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), which is [490,492) with defaults.
- `frame_count` increments on the counter wrap (`hc` = 799, `vc` = 524). Its new value is visible in the same cycle `frame_start` is high. The first `frame_start` after reset does not increment it. Wraps 0xFFFF -> 0x0000.
- Reset asserted asynchronously, including mid-frame:
  - counters go to 0
  - `DrawX` = 0, `DrawY` = 0, `blank` = 0, `hs` = 1, `vs` = 1, `line_start` = 0, `frame_start` = 0, `frame_count` = 0
  - all outputs hold these values while `reset` is high

## Timing
- First posedge after `reset` falls: `DrawX` = 0, `DrawY` = 0, `blank` = 1, `line_start` = 1, `frame_start` = 1, `frame_count` = 0.
- Line period is 800 cycles; frame period is 420000 cycles.
- `DrawX` 639 -> 640 transition: `blank` falls in the same cycle that `DrawX` shows 640.
- `line_start` pulses 525 times per frame, including during the vertical blanking lines.
- Renderers register RGB one cycle after `DrawX` is presented. `hs`/`vs` therefore need `PIPE_DELAY` = 1 to align with the RGB output.

## Configuration
- Macro `VGA_SYNC_ALIGN_EN`.
- Defined: `hs` and `vs` each pass through a `PIPE_DELAY`-stage shift register (stages reset to 1). The sync edges lag their counter-derived position by `PIPE_DELAY` further cycles. `DrawX`, `DrawY`, `blank` and the strobes are not delayed.
- Undefined: no delay stages. `hs`/`vs` are aligned with `DrawX`/`DrawY` and `PIPE_DELAY` is ignored.

## Structure
- Shared package `vga_pkg` holds:
  - default timing constants
  - derived `H_TOTAL`, `V_TOTAL`, `HS_START`, `HS_END`, `VS_START`, `VS_END`
  - a `vga_coord_t` 10-bit typedef, reused by the renderers
- Sub-module `sync_delay_line`: parameterised depth, width 1, asynchronous-reset shift register with a configurable reset value. It is instantiated twice, for `hs` and `vs`, only under `VGA_SYNC_ALIGN_EN`.

## Test plan
- Release reset, run 420000 cycles:
  - exactly 307200 cycles with `blank` = 1
  - `frame_start` high at cycle 1 and cycle 420001
  - `frame_count` goes 0 -> 1 at cycle 420001
- Sample one line:
  - `hs` low for exactly 96 cycles, first low cycle at `DrawX` = 656 (macro off) or `DrawX` = 657 (macro on, `PIPE_DELAY` = 1)
- Sample one frame:
  - `vs` low for exactly 1600 cycles, covering `DrawY` 490..491
- Assert `reset` at `DrawX` = 300, `DrawY` = 200 for 3 cycles:
  - outputs take reset values immediately
  - after release, `DrawX` = 0, `DrawY` = 0 and `frame_start` = 1 on the first edge
- Force 65535 frames (preload `frame_count` = 0xFFFF through the backdoor):
  - next `frame_start` shows `frame_count` = 0x0000
- `PIPE_DELAY` = 4 with macro on:
  - `hs` falling edge at `DrawX` = 660
  - `blank` falling edge still at `DrawX` = 640

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and coordinate type for the 640x480@60 display path.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  typedef logic [9:0] vga_coord_t;

  function automatic vga_coord_t to_coord(input int value);
    return vga_coord_t'(value);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Width-1 shift register with asynchronous reset to a configurable value.
module sync_delay_line #(
  parameter int   DEPTH     = 1,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr <= {DEPTH{RESET_VAL}};
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: coordinates, blank, active-low syncs, strobes and frame counter.
// Build option: define VGA_SYNC_ALIGN_EN to delay hs/vs by PIPE_DELAY extra cycles.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam vga_coord_t LP_H_LAST   = to_coord(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam vga_coord_t LP_V_LAST   = to_coord(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam vga_coord_t LP_H_VIS    = to_coord(H_VISIBLE);
  localparam vga_coord_t LP_V_VIS    = to_coord(V_VISIBLE);
  localparam vga_coord_t LP_HS_START = to_coord(H_VISIBLE + H_FP);
  localparam vga_coord_t LP_HS_END   = to_coord(H_VISIBLE + H_FP + H_SYNC);
  localparam vga_coord_t LP_VS_START = to_coord(V_VISIBLE + V_FP);
  localparam vga_coord_t LP_VS_END   = to_coord(V_VISIBLE + V_FP + V_SYNC);

  vga_coord_t  r_hc;
  vga_coord_t  r_vc;
  vga_coord_t  r_draw_x;
  vga_coord_t  r_draw_y;
  logic        r_blank;
  logic        r_hs;
  logic        r_vs;
  logic        r_line_start;
  logic        r_frame_start;
  logic [15:0] r_frame_count;
  logic        r_first;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_origin;
  logic w_blank;
  logic w_hs;
  logic w_vs;

  assign w_h_wrap = (r_hc == LP_H_LAST);
  assign w_v_wrap = (r_vc == LP_V_LAST);
  assign w_origin = (r_hc == '0) && (r_vc == '0);
  assign w_blank  = (r_hc < LP_H_VIS) && (r_vc < LP_V_VIS);
  assign w_hs     = !((r_hc >= LP_HS_START) && (r_hc < LP_HS_END));
  assign w_vs     = !((r_vc >= LP_VS_START) && (r_vc < LP_VS_END));

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_wrap) begin
      r_hc <= '0;
      r_vc <= w_v_wrap ? '0 : r_vc + 1'b1;
    end else begin
      r_hc <= r_hc + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_draw_x      <= '0;
      r_draw_y      <= '0;
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_draw_x      <= r_hc;
      r_draw_y      <= r_vc;
      r_blank       <= w_blank;
      r_hs          <= w_hs;
      r_vs          <= w_vs;
      r_line_start  <= (r_hc == '0);
      r_frame_start <= w_origin;
    end
  end

  // The origin right after reset is the first frame, not a completed one,
  // so it is skipped; later origins bump the count in step with frame_start.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_first       <= 1'b1;
      r_frame_count <= '0;
    end else begin
      r_first <= 1'b0;
      if (w_origin && !r_first) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign DrawX       = r_draw_x;
  assign DrawY       = r_draw_y;
  assign blank       = r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

`ifdef VGA_SYNC_ALIGN_EN
  logic w_hs_dly;
  logic w_vs_dly;

  sync_delay_line #(
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(1'b1)
  ) u_hs_dly (
    .i_clk(vga_clk),
    .i_rst(reset),
    .i_d  (r_hs),
    .o_q  (w_hs_dly)
  );

  sync_delay_line #(
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(1'b1)
  ) u_vs_dly (
    .i_clk(vga_clk),
    .i_rst(reset),
    .i_d  (r_vs),
    .o_q  (w_vs_dly)
  );

  assign hs = w_hs_dly;
  assign vs = w_vs_dly;
`else
  assign hs = r_hs;
  assign vs = r_vs;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunk raster so several whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HV = 16, HFP = 2, HSW = 4, HBP = 3;
  localparam int VV = 12, VFP = 2, VSW = 2, VBP = 3;
  localparam int TB_PIPE = 2;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;
  localparam int FT = HT * VT;
`ifdef VGA_SYNC_ALIGN_EN
  localparam int DLY = TB_PIPE;
`else
  localparam int DLY = 0;
`endif

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  int n_vec   = 0;
  int n_mis   = 0;
  int t       = 0;   // posedges seen since reset release
  int fc_base = 0;   // frame counter value at pixel position 0

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIPE_DELAY(TB_PIPE)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .hs         (hs),
    .vs         (vs),
    .line_start (line_start),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Expected outputs derived from raster position p = t-1.
  task automatic check_model();
    int p, x, y, q, xq, yq;
    logic e_hs, e_vs;
    if (reset || t == 0) begin
      check_val("rst_x",  32'(DrawX), 0);
      check_val("rst_y",  32'(DrawY), 0);
      check_val("rst_blank", 32'(blank), 0);
      check_val("rst_hs", 32'(hs), 1);
      check_val("rst_vs", 32'(vs), 1);
      check_val("rst_ls", 32'(line_start), 0);
      check_val("rst_fs", 32'(frame_start), 0);
      check_val("rst_fc", 32'(frame_count), 0);
      return;
    end
    p = t - 1;
    x = p % HT;
    y = (p / HT) % VT;
    q = p - DLY;
    if (q < 0) begin
      e_hs = 1'b1;
      e_vs = 1'b1;
    end else begin
      xq = q % HT;
      yq = (q / HT) % VT;
      e_hs = !(xq >= HV + HFP && xq < HV + HFP + HSW);
      e_vs = !(yq >= VV + VFP && yq < VV + VFP + VSW);
    end
    check_val("drawx", 32'(DrawX), 32'(x));
    check_val("drawy", 32'(DrawY), 32'(y));
    check_val("blank", 32'(blank), 32'(x < HV && y < VV));
    check_val("hs", 32'(hs), 32'(e_hs));
    check_val("vs", 32'(vs), 32'(e_vs));
    check_val("line_start", 32'(line_start), 32'(x == 0));
    check_val("frame_start", 32'(frame_start), 32'(x == 0 && y == 0));
    check_val("frame_count", 32'(frame_count), 32'(fc_base + p / FT) & 32'hFFFF);
  endtask

  task automatic tick();
    @(posedge vga_clk);
    if (!reset) t++;
    @(negedge vga_clk);
    check_model();
  endtask

  // Called just after a negedge: reset lands mid-cycle, away from any edge.
  task automatic async_reset(input int hold);
    #3;
    reset   = 1'b1;
    t       = 0;
    fc_base = 0;
    #1;
    check_model();
    repeat (hold) tick();
    reset = 1'b0;
  endtask

  task automatic preload_fc(input logic [15:0] val);
    force dut.r_frame_count = val;
    #1;
    release dut.r_frame_count;
    fc_base = int'(val) - (t - 1) / FT;
  endtask

  initial begin
    int nblank, nhs, nvs, first_hs_x, first_vs_x, first_vs_y, r;
    bit found;
    nblank = 0; nhs = 0; nvs = 0;
    first_hs_x = -1; first_vs_x = -1; first_vs_y = -1;

    repeat (2) tick();
    reset = 1'b0;

    for (int i = 1; i <= 2 * FT + 1; i++) begin
      tick();
      if (i <= FT && blank) nblank++;
      if (i == 1) begin
        check_val("first_fs", 32'(frame_start), 1);
        check_val("first_fc", 32'(frame_count), 0);
      end
      if (i == FT + 1) begin
        check_val("second_fs", 32'(frame_start), 1);
        check_val("second_fc", 32'(frame_count), 1);
      end
      if (i > FT && i <= 2 * FT) begin
        if (!hs) begin
          nhs++;
          if (first_hs_x < 0) first_hs_x = int'(DrawX);
        end
        if (!vs) begin
          nvs++;
          if (first_vs_y < 0) begin
            first_vs_y = int'(DrawY);
            first_vs_x = int'(DrawX);
          end
        end
      end
    end
    check_val("blank_count", 32'(nblank), 32'(HV * VV));
    check_val("hs_low_count", 32'(nhs), 32'(HSW * VT));
    check_val("vs_low_count", 32'(nvs), 32'(VSW * HT));
    check_val("hs_first_x", 32'(first_hs_x), 32'(HV + HFP + DLY));
    check_val("vs_first_y", 32'(first_vs_y), 32'(VV + VFP));
    check_val("vs_first_x", 32'(first_vs_x), 32'(DLY));

    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      tick();
      if ((t - 1) % HT == 10 && ((t - 1) / HT) % VT == 5) found = 1'b1;
    end
    check_val("find_mid_frame", 32'(found), 1);
    async_reset(3);
    tick();
    check_val("post_rst_x", 32'(DrawX), 0);
    check_val("post_rst_y", 32'(DrawY), 0);
    check_val("post_rst_fs", 32'(frame_start), 1);

    repeat (37) tick();
    preload_fc(16'hFFFF);
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      tick();
      if (frame_start) found = 1'b1;
    end
    check_val("wrap_seen", 32'(found), 1);
    check_val("wrap_fc", 32'(frame_count), 0);

    for (int i = 0; i < 20000; i++) begin
      tick();
      r = int'($urandom_range(0, 999));
      if (r < 3) async_reset(int'($urandom_range(1, 3)));
      else if (r < 6 && t > 0) preload_fc(16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
